id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating bubble counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hold all stage registers this cycle.
REQ-005 flush  input  1  load a bubble this cycle; overrides stall.
REQ-006 id_valid  input  1  decode stage presents a valid instruction.
REQ-007 id_rs_data, id_rt_data  input  32 each  register-file read data.
REQ-008 id_imm  input  32  extended immediate; id_shamt  input  5  shift amount.
REQ-009 id_rs, id_rt, id_rd  input  5 each  source and destination register numbers.
REQ-010 id_alufun  input  6  ALU function code; id_sign  input  1  signed-arithmetic flag.
REQ-011 id_srca_shamt, id_srcb_imm, id_reg_write  input  1 each  operand selects and writeback enable.
REQ-012 exmem_reg_write  input  1; exmem_rd  input  5; exmem_result  input  32  EX/MEM forwarding source.
REQ-013 memwb_reg_write  input  1; memwb_rd  input  5; memwb_result  input  32  MEM/WB forwarding source.
REQ-014 ex_valid  output  1  the EX slot holds a real instruction.
REQ-015 alu_a, alu_b  output  32 each  ALU operands; alu_fun  output  6; alu_sign  output  1.
REQ-016 ex_store_data  output  32  forwarded rt value for stores; ex_rd  output  5; ex_reg_write  output  1.
REQ-017 bubble_cnt  output  CNT_W  count of bubble cycles inserted since reset.

Function
REQ-018 On each rising clk edge, if flush=1, the stage SHALL load a bubble: valid=0, reg_write=0, rd=0, alufun=0, and all data fields cleared to 0.
REQ-019 If flush=0 and stall=1, the stage SHALL hold every register unchanged.
REQ-020 Otherwise the stage SHALL capture all id_* inputs, with valid=id_valid and reg_write=id_reg_write&id_valid.
REQ-021 Latency: an id_* value presented before edge N SHALL appear on the outputs after edge N, exactly one cycle.
REQ-022 Forwarding SHALL be combinational from the registered rs/rt numbers: EX/MEM is selected when exmem_reg_write=1, exmem_rd!=0 and exmem_rd equals the register number; otherwise MEM/WB is selected under the same conditions; otherwise the registered register-file data is used.
REQ-023 EX/MEM SHALL take priority over MEM/WB when both match, and register 0 SHALL never be forwarded.
REQ-024 alu_a SHALL be {27'b0, shamt} when srca_shamt=1, otherwise the forwarded rs value.
REQ-025 alu_b SHALL be imm when srcb_imm=1, otherwise the forwarded rt value.
REQ-026 ex_store_data SHALL always be the forwarded rt value, regardless of srcb_imm.
REQ-027 When ex_valid=0, ex_reg_write SHALL be 0.
REQ-028 bubble_cnt SHALL increment on every edge where flush=1, or where stall=0 and id_valid=0.
REQ-029 bubble_cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-030 While reset=0, asynchronously and independent of clk, all stage registers and bubble_cnt SHALL be 0, so every output is 0 and ex_valid=0.
REQ-031 On reset deassertion, the first capture SHALL occur at the next rising clk edge.
REQ-032 Reset asserted mid-stall or mid-flush SHALL discard the held instruction.

Configuration
REQ-033 With macro ID_EX_FORWARD_EN defined, forwarding SHALL operate as in REQ-022 and REQ-023.
REQ-034 Without ID_EX_FORWARD_EN, the registered register-file data SHALL always be used, and the exmem_*/memwb_* inputs SHALL be ignored.

Structure
REQ-035 A shared package SHALL hold the forward-select encoding (FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2), the 6-bit ALU function width and the bubble field constants.
REQ-036 Forward-source selection SHALL be implemented in a single sub-module, fwd_select, instantiated twice (rs and rt).

Verification
REQ-037 Reset=0 mid-operation with ex_valid=1 -> all outputs 0 immediately, before any clk edge.
REQ-038 id_rs=5, id_rs_data=0x11; exmem_rd=5, exmem_reg_write=1, exmem_result=0xAA; memwb_rd=5, memwb_reg_write=1, memwb_result=0xBB -> alu_a=0xAA. Without the macro -> alu_a=0x11.
REQ-039 id_rt=0 with exmem_rd=0 and exmem_reg_write=1 -> alu_b equals the registered id_rt_data, not forwarded.
REQ-040 stall=1 and flush=1 on the same edge -> ex_valid=0, ex_reg_write=0, and bubble_cnt increments by 1.
REQ-041 stall=1 for 3 cycles with new id_* values presented -> outputs unchanged throughout; new values captured on the first edge with stall=0.
REQ-042 CNT_W=4 and 20 flush cycles -> bubble_cnt=15, holding at 15.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline stage:
//   - fwd_sel_t    : operand forward-source encoding (RF / EX-MEM / MEM-WB)
//   - ALUFUN_W     : width of the ALU function code
//   - BUBBLE_*     : field values loaded when the stage is flushed
//   - ex_regs_t    : packed image of every ID/EX stage register
//   - bubble_regs(): helper that builds a bubble from the BUBBLE_* constants
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  localparam int ALUFUN_W = 6;

  localparam logic                BUBBLE_VALID     = 1'b0;
  localparam logic                BUBBLE_REG_WRITE = 1'b0;
  localparam logic [4:0]          BUBBLE_RD        = 5'd0;
  localparam logic [ALUFUN_W-1:0] BUBBLE_ALUFUN    = '0;
  localparam logic [31:0]         BUBBLE_DATA      = 32'd0;

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic [4:0]          rd;
    logic [ALUFUN_W-1:0] alufun;
    logic                sign;
    logic                srca_shamt;
    logic                srcb_imm;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [31:0]         rs_data;
    logic [31:0]         rt_data;
    logic [31:0]         imm;
    logic [4:0]          shamt;
  } ex_regs_t;

  // A bubble is a fully cleared slot: no writeback, register 0 everywhere
  // (so it can never match a forwarding source) and zero data.
  function automatic ex_regs_t bubble_regs();
    ex_regs_t b;
    b            = '0;
    b.valid      = BUBBLE_VALID;
    b.reg_write  = BUBBLE_REG_WRITE;
    b.rd         = BUBBLE_RD;
    b.alufun     = BUBBLE_ALUFUN;
    b.rs_data    = BUBBLE_DATA;
    b.rt_data    = BUBBLE_DATA;
    b.imm        = BUBBLE_DATA;
    return b;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Chooses the value of one source operand: EX/MEM result, MEM/WB result or
// the registered register-file data. EX/MEM wins over MEM/WB (it is the
// younger producer) and register 0 is never forwarded.
// Parameter FWD_EN: 1 enables forwarding, 0 always returns rf_data. The top
// sets it from macro ID_EX_FORWARD_EN.
// Ports:
//   src_reg          in  5   registered source register number
//   rf_data          in  32  registered register-file data
//   exmem_reg_write  in  1   EX/MEM writeback enable
//   exmem_rd         in  5   EX/MEM destination register
//   exmem_result     in  32  EX/MEM result
//   memwb_reg_write  in  1   MEM/WB writeback enable
//   memwb_rd         in  5   MEM/WB destination register
//   memwb_result     in  32  MEM/WB result
//   data             out 32  forwarded operand value
// ---------------------------------------------------------------------------
module fwd_select
  import id_ex_stage_pkg::*;
#(
  parameter bit FWD_EN = 1'b0
) (
  input  logic [4:0]  src_reg,
  input  logic [31:0] rf_data,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] data
);

  fwd_sel_t sel;
  logic     exmem_hit;
  logic     memwb_hit;

  assign exmem_hit = FWD_EN && exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == src_reg);
  assign memwb_hit = FWD_EN && memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == src_reg);

  always_comb begin
    sel = FWD_RF;
    if (exmem_hit)      sel = FWD_EXMEM;
    else if (memwb_hit) sel = FWD_MEMWB;
  end

  always_comb begin
    data = rf_data;
    case (sel)
      FWD_EXMEM: data = exmem_result;
      FWD_MEMWB: data = memwb_result;
      default:   data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with stall/flush control, operand forwarding into
// the ALU inputs and a saturating count of inserted bubble cycles.
// Configuration macro: ID_EX_FORWARD_EN -- when defined, operands are
// forwarded from EX/MEM and MEM/WB; otherwise the registered register-file
// data is always used and the exmem_*/memwb_* inputs have no effect.
// Ports:
//   clk, reset (async, active-low)
//   stall, flush (flush overrides stall)
//   id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_rs, id_rt, id_rd,
//   id_alufun, id_sign, id_srca_shamt, id_srcb_imm, id_reg_write : decode in
//   exmem_reg_write, exmem_rd, exmem_result : EX/MEM forwarding source
//   memwb_reg_write, memwb_rd, memwb_result : MEM/WB forwarding source
//   ex_valid, alu_a, alu_b, alu_fun, alu_sign, ex_store_data, ex_rd,
//   ex_reg_write : EX-side outputs
//   bubble_cnt [CNT_W] : bubbles inserted since reset, saturating
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [31:0]         id_rs_data,
  input  logic [31:0]         id_rt_data,
  input  logic [31:0]         id_imm,
  input  logic [4:0]          id_shamt,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic [4:0]          id_rd,
  input  logic [ALUFUN_W-1:0] id_alufun,
  input  logic                id_sign,
  input  logic                id_srca_shamt,
  input  logic                id_srcb_imm,
  input  logic                id_reg_write,
  input  logic                exmem_reg_write,
  input  logic [4:0]          exmem_rd,
  input  logic [31:0]         exmem_result,
  input  logic                memwb_reg_write,
  input  logic [4:0]          memwb_rd,
  input  logic [31:0]         memwb_result,
  output logic                ex_valid,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic [ALUFUN_W-1:0] alu_fun,
  output logic                alu_sign,
  output logic [31:0]         ex_store_data,
  output logic [4:0]          ex_rd,
  output logic                ex_reg_write,
  output logic [CNT_W-1:0]    bubble_cnt
);

`ifdef ID_EX_FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_regs_t         ex_q;
  ex_regs_t         ex_capture;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic             bubble_inc;
  logic [31:0]      rs_fwd;
  logic [31:0]      rt_fwd;

  // Decode-side image of the stage registers; writeback is only enabled
  // for a valid instruction so a non-valid slot can never write.
  always_comb begin
    ex_capture            = '0;
    ex_capture.valid      = id_valid;
    ex_capture.reg_write  = id_reg_write & id_valid;
    ex_capture.rd         = id_rd;
    ex_capture.alufun     = id_alufun;
    ex_capture.sign       = id_sign;
    ex_capture.srca_shamt = id_srca_shamt;
    ex_capture.srcb_imm   = id_srcb_imm;
    ex_capture.rs         = id_rs;
    ex_capture.rt         = id_rt;
    ex_capture.rs_data    = id_rs_data;
    ex_capture.rt_data    = id_rt_data;
    ex_capture.imm        = id_imm;
    ex_capture.shamt      = id_shamt;
  end

  // A bubble cycle is either a flush or a free-running capture of a
  // non-valid decode slot; a stalled cycle inserts nothing.
  assign bubble_inc = flush | (~stall & ~id_valid);

  // Stage registers and bubble counter. Flush beats stall; the counter
  // sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (flush)       ex_q <= bubble_regs();
      else if (!stall) ex_q <= ex_capture;
      if (bubble_inc && !(&bubble_cnt_q)) bubble_cnt_q <= bubble_cnt_q + CntOne;
    end
  end

  fwd_select #(.FWD_EN(FwdEn)) u_fwd_rs (
    .src_reg         (ex_q.rs),
    .rf_data         (ex_q.rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (rs_fwd)
  );

  fwd_select #(.FWD_EN(FwdEn)) u_fwd_rt (
    .src_reg         (ex_q.rt),
    .rf_data         (ex_q.rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (rt_fwd)
  );

  assign ex_valid      = ex_q.valid;
  assign alu_fun       = ex_q.alufun;
  assign alu_sign      = ex_q.sign;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write & ex_q.valid;
  assign alu_a         = ex_q.srca_shamt ? {27'b0, ex_q.shamt} : rs_fwd;
  assign alu_b         = ex_q.srcb_imm ? ex_q.imm : rt_fwd;
  // Stores always need the real rt value even when alu_b carries the offset.
  assign ex_store_data = rt_fwd;
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed, table-driven bench for id_ex_stage (CNT_W=4 so that counter
// saturation is reachable). Expected values are hand-computed; where the
// result depends on ID_EX_FORWARD_EN the bench follows the same macro.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  fun;
    logic        sign;
    logic        sa;
    logic        sb;
    logic        rw;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] mres;
  } in_t;

  typedef struct packed {
    logic        ev;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [5:0]  ef;
    logic        es;
    logic [31:0] esd;
    logic [4:0]  erd;
    logic        erw;
    logic [3:0]  ecnt;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic [5:0]  id_alufun;
  logic        id_sign, id_srca_shamt, id_srcb_imm, id_reg_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic [3:0]  bubble_cnt;

  int   nVectors = 0;
  int   nMiscompares = 0;
  vec_t vecs[$];

  id_ex_stage #(.CNT_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_shamt        (id_shamt),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_alufun       (id_alufun),
    .id_sign         (id_sign),
    .id_srca_shamt   (id_srca_shamt),
    .id_srcb_imm     (id_srcb_imm),
    .id_reg_write    (id_reg_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .ex_valid        (ex_valid),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_fun         (alu_fun),
    .alu_sign        (alu_sign),
    .ex_store_data   (ex_store_data),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .bubble_cnt      (bubble_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

  function automatic in_t mkIn(input logic [4:0] rs, input logic [31:0] rsd,
                               input logic [4:0] rt, input logic [31:0] rtd,
                               input logic [4:0] rd, input logic [5:0] fun);
    in_t x;
    x       = '0;
    x.valid = 1'b1;
    x.rw    = 1'b1;
    x.rs    = rs;
    x.rsd   = rsd;
    x.rt    = rt;
    x.rtd   = rtd;
    x.rd    = rd;
    x.fun   = fun;
    return x;
  endfunction

  function automatic exp_t mkExp(input logic ev, input logic [31:0] ea, input logic [31:0] eb,
                                 input logic [5:0] ef, input logic es, input logic [31:0] esd,
                                 input logic [4:0] erd, input logic erw, input logic [3:0] ecnt);
    exp_t x;
    x.ev = ev; x.ea = ea; x.eb = eb; x.ef = ef; x.es = es;
    x.esd = esd; x.erd = erd; x.erw = erw; x.ecnt = ecnt;
    return x;
  endfunction

  function automatic exp_t sampleDut();
    return mkExp(ex_valid, alu_a, alu_b, alu_fun, alu_sign, ex_store_data, ex_rd, ex_reg_write, bubble_cnt);
  endfunction

  task automatic driveIn(input in_t t);
    stall = t.stall; flush = t.flush; id_valid = t.valid;
    id_rs_data = t.rsd; id_rt_data = t.rtd; id_imm = t.imm; id_shamt = t.shamt;
    id_rs = t.rs; id_rt = t.rt; id_rd = t.rd; id_alufun = t.fun; id_sign = t.sign;
    id_srca_shamt = t.sa; id_srcb_imm = t.sb; id_reg_write = t.rw;
    exmem_reg_write = t.xw; exmem_rd = t.xrd; exmem_result = t.xres;
    memwb_reg_write = t.mw; memwb_rd = t.mrd; memwb_result = t.mres;
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic applyStimulus(input in_t t);
    @(negedge clk);
    driveIn(t);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t got;
    got = sampleDut();
    nVectors++;
    if (got !== e) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got v=%b a=%h b=%h fun=%h s=%b sd=%h rd=%0d rw=%b cnt=%0d, want v=%b a=%h b=%h fun=%h s=%b sd=%h rd=%0d rw=%b cnt=%0d",
               name, got.ev, got.ea, got.eb, got.ef, got.es, got.esd, got.erd, got.erw, got.ecnt,
               e.ev, e.ea, e.eb, e.ef, e.es, e.esd, e.erd, e.erw, e.ecnt);
    end
  endtask

  task automatic addVec(input in_t t, input exp_t x);
    vec_t v;
    v.i = t;
    v.e = x;
    vecs.push_back(v);
  endtask

  initial begin
    in_t  t;
    in_t  tx;
    in_t  ty;
    exp_t zero2;
    exp_t zero3;
    exp_t expX;

    // ---------------- vector table ----------------
    // 0: plain register operands
    t = mkIn(5'd1, 32'h100, 5'd2, 32'h200, 5'd3, 6'h21);
    t.imm = 32'h1234; t.shamt = 5'd3; t.sign = 1'b1;
    addVec(t, mkExp(1, 32'h100, 32'h200, 6'h21, 1, 32'h200, 5'd3, 1, 4'd0));
    // 1: shamt and immediate selects
    t = mkIn(5'd4, 32'h5, 5'd6, 32'h6, 5'd9, 6'h02);
    t.sa = 1'b1; t.sb = 1'b1; t.shamt = 5'd7; t.imm = 32'hFFFF0000;
    addVec(t, mkExp(1, 32'h7, 32'hFFFF0000, 6'h02, 0, 32'h6, 5'd9, 1, 4'd0));
    // 2: non-valid slot: data captured, writeback suppressed, one bubble
    t = mkIn(5'd1, 32'h77, 5'd2, 32'h88, 5'd10, 6'h03);
    t.valid = 1'b0;
    addVec(t, mkExp(0, 32'h77, 32'h88, 6'h03, 0, 32'h88, 5'd10, 0, 4'd1));
    // 3: both sources match rs, EX/MEM wins
    t = mkIn(5'd5, 32'h11, 5'd7, 32'h22, 5'd1, 6'h20);
    t.xw = 1; t.xrd = 5'd5; t.xres = 32'hAA; t.mw = 1; t.mrd = 5'd5; t.mres = 32'hBB;
    addVec(t, mkExp(1, FWD ? 32'hAA : 32'h11, 32'h22, 6'h20, 0, 32'h22, 5'd1, 1, 4'd1));
    // 4: rs from MEM/WB, rt from EX/MEM
    t = mkIn(5'd5, 32'h11, 5'd8, 32'h33, 5'd2, 6'h22);
    t.xw = 1; t.xrd = 5'd8; t.xres = 32'hCC; t.mw = 1; t.mrd = 5'd5; t.mres = 32'hBB;
    addVec(t, mkExp(1, FWD ? 32'hBB : 32'h11, FWD ? 32'hCC : 32'h33, 6'h22, 0,
                    FWD ? 32'hCC : 32'h33, 5'd2, 1, 4'd1));
    // 5: register 0 is never forwarded
    t = mkIn(5'd3, 32'h55, 5'd0, 32'h44, 5'd4, 6'h23);
    t.xw = 1; t.xrd = 5'd0; t.xres = 32'hDD; t.mw = 1; t.mrd = 5'd0; t.mres = 32'hEE;
    addVec(t, mkExp(1, 32'h55, 32'h44, 6'h23, 0, 32'h44, 5'd4, 1, 4'd1));
    // 6: EX/MEM not writing -> MEM/WB; store data ignores the immediate
    t = mkIn(5'd6, 32'h66, 5'd9, 32'h99, 5'd5, 6'h24);
    t.sb = 1'b1; t.imm = 32'h10;
    t.xw = 0; t.xrd = 5'd6; t.xres = 32'hAB; t.mw = 1; t.mrd = 5'd6; t.mres = 32'hBC;
    addVec(t, mkExp(1, FWD ? 32'hBC : 32'h66, 32'h10, 6'h24, 0, 32'h99, 5'd5, 1, 4'd1));
    // 7: flush over a valid instruction
    zero2 = mkExp(0, 32'h0, 32'h0, 6'h0, 0, 32'h0, 5'd0, 0, 4'd2);
    zero3 = mkExp(0, 32'h0, 32'h0, 6'h0, 0, 32'h0, 5'd0, 0, 4'd3);
    t = mkIn(5'd1, 32'h123, 5'd2, 32'h456, 5'd7, 6'h25);
    t.flush = 1'b1;
    addVec(t, zero2);
    // 8: refill
    t = mkIn(5'd1, 32'h100, 5'd2, 32'h200, 5'd3, 6'h21);
    t.imm = 32'h1234; t.shamt = 5'd3; t.sign = 1'b1;
    addVec(t, mkExp(1, 32'h100, 32'h200, 6'h21, 1, 32'h200, 5'd3, 1, 4'd2));
    // 9: stall and flush together -> bubble, counted once
    t = mkIn(5'd1, 32'h123, 5'd2, 32'h456, 5'd7, 6'h25);
    t.stall = 1'b1; t.flush = 1'b1;
    addVec(t, zero3);
    // 10: stalled non-valid slot is not a bubble
    t = '0; t.stall = 1'b1;
    addVec(t, zero3);
    // 11: load X, 12-14: stall while Y is presented, 15: Y captured
    tx = mkIn(5'd11, 32'h1111, 5'd12, 32'h2222, 5'd13, 6'h2A);
    tx.imm = 32'h3333; tx.shamt = 5'd1; tx.sign = 1'b1;
    expX = mkExp(1, 32'h1111, 32'h2222, 6'h2A, 1, 32'h2222, 5'd13, 1, 4'd3);
    addVec(tx, expX);
    ty = mkIn(5'd14, 32'h4444, 5'd15, 32'h5555, 5'd16, 6'h2B);
    ty.imm = 32'h6666; ty.shamt = 5'd2; ty.sa = 1'b1; ty.sb = 1'b1; ty.stall = 1'b1;
    for (int k = 0; k < 3; k++) addVec(ty, expX);
    ty.stall = 1'b0;
    addVec(ty, mkExp(1, 32'h2, 32'h6666, 6'h2B, 0, 32'h5555, 5'd16, 1, 4'd3));

    // ---------------- reset state ----------------
    reset = 1'b0;
    driveIn(vecs[0].i);
    #3;
    checkOutput("reset_state", mkExp(0, 32'h0, 32'h0, 6'h0, 0, 32'h0, 5'd0, 0, 4'd0));
    @(negedge clk);
    reset = 1'b1;

    // ---------------- table loop ----------------
    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n].i);
      checkOutput($sformatf("vec%0d", n), vecs[n].e);
    end

    // ---------------- async reset mid-stall ----------------
    @(negedge clk);
    t = tx; t.stall = 1'b1;
    driveIn(t);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_mid_stall", mkExp(0, 32'h0, 32'h0, 6'h0, 0, 32'h0, 5'd0, 0, 4'd0));
    t.stall = 1'b0;
    driveIn(t);
    @(posedge clk);
    #1;
    checkOutput("held_in_reset", mkExp(0, 32'h0, 32'h0, 6'h0, 0, 32'h0, 5'd0, 0, 4'd0));
    @(negedge clk);
    reset = 1'b1;
    t = mkIn(5'd1, 32'h7, 5'd2, 32'h8, 5'd3, 6'h01);
    driveIn(t);
    @(posedge clk);
    #1;
    checkOutput("first_capture_after_reset", mkExp(1, 32'h7, 32'h8, 6'h01, 0, 32'h8, 5'd3, 1, 4'd0));

    // ---------------- bubble counter saturation ----------------
    for (int k = 1; k <= 20; k++) begin
      t = '0; t.flush = 1'b1;
      applyStimulus(t);
      checkOutput($sformatf("flush_sat_%0d", k),
                  mkExp(0, 32'h0, 32'h0, 6'h0, 0, 32'h0, 5'd0, 0, (k > 15) ? 4'd15 : 4'(k)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
